// File: rtl/apu_mixer_pkg.sv
// Purpose: shared types, constants and DAC conversion helper for the APU stereo mixer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package apu_mixer_pkg;

    // Signed accumulator width: four channels of -15..+15 sum to -60..+60.
    localparam int ACC_W = 7;
    // Width of one signed channel contribution (-15..+15).
    localparam int CTB_W = 5;

    // Mixer sequencer states; FILTER is only reachable in the high-pass build.
    typedef enum logic [2:0] {
        IDLE,
        CH1,
        CH2,
        CH3,
        CH4,
        SCALE,
        FILTER
    } mix_state_t;

    // Per-sample snapshot of every mixer input, captured on the accepted strobe.
    typedef struct packed {
        logic [3:0][3:0] dac;
        logic [3:0]      en;
        logic [3:0]      lmix;
        logic [3:0]      rmix;
        logic [2:0]      lvol;
        logic [2:0]      rvol;
    } mix_cfg_t;

    // Map an unsigned 0..15 DAC code onto a symmetric -15..+15 level; a powered-off DAC is silent.
    function automatic logic signed [CTB_W-1:0] dac_to_signed(input logic [3:0] code, input logic en);
        logic signed [5:0] wide;
        wide = $signed({1'b0, code, 1'b0}) - 6'sd15;
        return en ? wide[CTB_W-1:0] : '0;
    endfunction

endpackage

// File: rtl/apu_mixer_hpf.sv
// Purpose: single-pole DC-blocking filter for one mixer side (y = x - cap, cap tracks x slowly).
// Latency: y is combinational from x; cap advances one step per en pulse.
// Backpressure: none; caller pulses en once per sample.
module apu_mixer_hpf #(
    parameter int OUT_W     = 10,
    parameter int HPF_SHIFT = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic signed [OUT_W-1:0] x,
    output logic signed [OUT_W-1:0] y
);

    // cap holds OUT_W integer bits plus HPF_SHIFT fractional bits.
    localparam int CAP_W = OUT_W + HPF_SHIFT;

    logic signed [CAP_W-1:0] cap_q;
    logic signed [CAP_W:0]   diff;
    logic signed [OUT_W:0]   y_wide;
    logic signed [OUT_W-1:0] cap_int;

    assign cap_int = OUT_W'(cap_q >>> HPF_SHIFT);
    assign diff    = ((CAP_W + 1)'(x) <<< HPF_SHIFT) - (CAP_W + 1)'(cap_q);
    assign y_wide  = (OUT_W + 1)'(x) - (OUT_W + 1)'(cap_int);

    // Clamp the filtered output: a full-scale step against an opposite-sign cap can exceed OUT_W.
    always_comb begin
        y = y_wide[OUT_W-1:0];
        if (y_wide[OUT_W] != y_wide[OUT_W-1]) begin
            y = y_wide[OUT_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

    // Move cap a 2^-HPF_SHIFT fraction of the way towards x each sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_q <= '0;
        end else if (en) begin
            cap_q <= cap_q + CAP_W'(diff >>> HPF_SHIFT);
        end
    end

endmodule

// File: rtl/apu_mixer.sv
// Purpose: serial 4-channel stereo mixer with NR51 routing and NR50 master volume (optional APU_MIXER_HPF_EN DC block).
// Latency: out_valid 6 clocks after an accepted strobe (7 with APU_MIXER_HPF_EN).
// Backpressure: none; strobes arriving while busy are dropped and flagged on sticky overrun.
module apu_mixer
    import apu_mixer_pkg::*;
#(
    parameter int OUT_W     = 10,
    parameter int HPF_SHIFT = 8
) (
    input  logic                    apuv_4mhz,
    input  logic                    apu_reset,
    input  logic                    sample_stb,
    input  logic [3:0]              ch1_dac,
    input  logic [3:0]              ch2_dac,
    input  logic [3:0]              ch3_dac,
    input  logic [3:0]              ch4_dac,
    input  logic [3:0]              dac_en,
    input  logic [3:0]              lmixer,
    input  logic [3:0]              rmixer,
    input  logic [2:0]              lvol,
    input  logic [2:0]              rvol,
    output logic signed [OUT_W-1:0] left_out,
    output logic signed [OUT_W-1:0] right_out,
    output logic                    out_valid,
    output logic                    busy,
    output logic                    overrun
);

    // Out-of-range parameters stop elaboration rather than silently truncating samples.
    if (OUT_W < 10 || HPF_SHIFT < 1) begin : g_param_check
        $error("apu_mixer: OUT_W must be >= 10 and HPF_SHIFT >= 1");
    end

    mix_state_t              state_q, state_d;
    mix_cfg_t                cfg_q;
    mix_cfg_t                cfg_snap;
    logic signed [ACC_W-1:0] acc_l, acc_r;
    logic [1:0]              ch_idx;
    logic                    ch_active;
    logic signed [CTB_W-1:0] ctb;
    logic signed [4:0]       lvol_m, rvol_m;
    logic signed [11:0]      prod_l, prod_r;
    logic signed [OUT_W-1:0] scaled_l, scaled_r;
    logic                    stb_accept;

    assign cfg_snap = '{
        dac:  {ch4_dac, ch3_dac, ch2_dac, ch1_dac},
        en:   dac_en,
        lmix: lmixer,
        rmix: rmixer,
        lvol: lvol,
        rvol: rvol
    };

    assign busy       = (state_q != IDLE);
    assign stb_accept = (state_q == IDLE) && sample_stb;

    // Pick which snapshotted channel the current sequencer state is summing.
    always_comb begin
        ch_idx    = 2'd0;
        ch_active = 1'b0;
        case (state_q)
            CH1: begin ch_idx = 2'd0; ch_active = 1'b1; end
            CH2: begin ch_idx = 2'd1; ch_active = 1'b1; end
            CH3: begin ch_idx = 2'd2; ch_active = 1'b1; end
            CH4: begin ch_idx = 2'd3; ch_active = 1'b1; end
            default: ;
        endcase
    end

    assign ctb = dac_to_signed(cfg_q.dac[ch_idx], cfg_q.en[ch_idx]);

    // Master volume is a 1..8 multiplier; products stay within -480..+480.
    assign lvol_m   = $signed({2'b00, cfg_q.lvol}) + 5'sd1;
    assign rvol_m   = $signed({2'b00, cfg_q.rvol}) + 5'sd1;
    assign prod_l   = 12'(acc_l) * 12'(lvol_m);
    assign prod_r   = 12'(acc_r) * 12'(rvol_m);
    assign scaled_l = OUT_W'(prod_l);
    assign scaled_r = OUT_W'(prod_r);

    // Sequencer next state: one channel per clock, then scale (and filter when enabled).
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (sample_stb) state_d = CH1;
            CH1:    state_d = CH2;
            CH2:    state_d = CH3;
            CH3:    state_d = CH4;
            CH4:    state_d = SCALE;
`ifdef APU_MIXER_HPF_EN
            SCALE:  state_d = FILTER;
`else
            SCALE:  state_d = IDLE;
`endif
            FILTER: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge apuv_4mhz) begin
        if (apu_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef APU_MIXER_HPF_EN
    logic signed [OUT_W-1:0] scl_l, scl_r;
    logic signed [OUT_W-1:0] filt_l, filt_r;
    logic                    filt_en;

    assign filt_en = (state_q == FILTER);

    apu_mixer_hpf #(.OUT_W(OUT_W), .HPF_SHIFT(HPF_SHIFT)) u_hpf_l (
        .clk (apuv_4mhz),
        .rst (apu_reset),
        .en  (filt_en),
        .x   (scl_l),
        .y   (filt_l)
    );

    apu_mixer_hpf #(.OUT_W(OUT_W), .HPF_SHIFT(HPF_SHIFT)) u_hpf_r (
        .clk (apuv_4mhz),
        .rst (apu_reset),
        .en  (filt_en),
        .x   (scl_r),
        .y   (filt_r)
    );
`endif

    // Datapath: snapshot on accept, accumulate per channel, scale, publish outputs, flag overruns.
    always_ff @(posedge apuv_4mhz) begin
        if (apu_reset) begin
            cfg_q     <= '0;
            acc_l     <= '0;
            acc_r     <= '0;
            left_out  <= '0;
            right_out <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
`ifdef APU_MIXER_HPF_EN
            scl_l     <= '0;
            scl_r     <= '0;
`endif
        end else begin
            out_valid <= 1'b0;

            if (stb_accept) begin
                cfg_q <= cfg_snap;
                acc_l <= '0;
                acc_r <= '0;
            end

            if (ch_active) begin
                if (cfg_q.lmix[ch_idx]) acc_l <= acc_l + ACC_W'(ctb);
                if (cfg_q.rmix[ch_idx]) acc_r <= acc_r + ACC_W'(ctb);
            end

            if (sample_stb && busy) begin
                overrun <= 1'b1;
            end

`ifdef APU_MIXER_HPF_EN
            if (state_q == SCALE) begin
                scl_l <= scaled_l;
                scl_r <= scaled_r;
            end
            if (state_q == FILTER) begin
                left_out  <= filt_l;
                right_out <= filt_r;
                out_valid <= 1'b1;
            end
`else
            if (state_q == SCALE) begin
                left_out  <= scaled_l;
                right_out <= scaled_r;
                out_valid <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_apu_mixer.sv
// Purpose: scoreboard bench for apu_mixer; directed vectors with hand-computed stereo samples.
// Latency: checks out_valid arrives 6 clocks after strobe is raised (default build).
// Backpressure: exercises strobes while busy (dropped, sticky overrun) and strobe coincident with out_valid.
module tb_apu_mixer;

    logic              clk = 1'b0;
    logic              apu_reset;
    logic              sample_stb;
    logic [3:0]        ch1_dac, ch2_dac, ch3_dac, ch4_dac;
    logic [3:0]        dac_en, lmixer, rmixer;
    logic [2:0]        lvol, rvol;
    logic signed [9:0] left_out, right_out;
    logic              out_valid, busy, overrun;

    typedef struct {
        int l;
        int r;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   lat   = 0;

    always #5 clk = ~clk;

    apu_mixer #(.OUT_W(10), .HPF_SHIFT(8)) dut (
        .apuv_4mhz  (clk),
        .apu_reset  (apu_reset),
        .sample_stb (sample_stb),
        .ch1_dac    (ch1_dac),
        .ch2_dac    (ch2_dac),
        .ch3_dac    (ch3_dac),
        .ch4_dac    (ch4_dac),
        .dac_en     (dac_en),
        .lmixer     (lmixer),
        .rmixer     (rmixer),
        .lvol       (lvol),
        .rvol       (rvol),
        .left_out   (left_out),
        .right_out  (right_out),
        .out_valid  (out_valid),
        .busy       (busy),
        .overrun    (overrun)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every out_valid pulse must match the oldest outstanding expected sample.
    always @(negedge clk) begin
        if (!apu_reset && out_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got out_valid=1 with L=%0d R=%0d, expected no sample",
                         int'(left_out), int'(right_out));
            end else begin
                mon_e = exp_q.pop_front();
                chk("left_out", int'(left_out), mon_e.l);
                chk("right_out", int'(right_out), mon_e.r);
            end
        end
    end

    // Called at #1 after an edge: present inputs, raise strobe for one edge, optionally queue the expected sample.
    task automatic start(input logic [3:0] c1, input logic [3:0] c2, input logic [3:0] c3, input logic [3:0] c4,
                         input logic [3:0] en, input logic [3:0] lm, input logic [3:0] rm,
                         input logic [2:0] lv, input logic [2:0] rv,
                         input bit push, input int el, input int er);
        exp_t e;
        ch1_dac = c1; ch2_dac = c2; ch3_dac = c3; ch4_dac = c4;
        dac_en = en; lmixer = lm; rmixer = rm; lvol = lv; rvol = rv;
        sample_stb = 1'b1;
        if (push) begin
            e.l = el;
            e.r = er;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        sample_stb = 1'b0;
        lat = 1;
    endtask

    task automatic wait_valid(input string name);
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no out_valid after %0d clocks, expected one at 6", name, lat);
        end else begin
            chk({name, "_latency"}, lat, 6);
        end
    endtask

    initial begin
        apu_reset = 1'b1; sample_stb = 1'b0;
        ch1_dac = '0; ch2_dac = '0; ch3_dac = '0; ch4_dac = '0;
        dac_en = '0; lmixer = '0; rmixer = '0; lvol = '0; rvol = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_left", int'(left_out), 0);
        chk("rst_right", int'(right_out), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_overrun", int'(overrun), 0);
        apu_reset = 1'b0;
        @(posedge clk); #1;

        // Full scale both sides: 4*15*8 = 480.
        start(4'd15, 4'd15, 4'd15, 4'd15, 4'hF, 4'hF, 4'hF, 3'd7, 3'd7, 1, 480, 480);
        chk("busy_after_stb", int'(busy), 1);
        wait_valid("all_max");
        // Back-to-back strobes below coincide with out_valid and must be accepted.
        start(4'd0, 4'd0, 4'd0, 4'd0, 4'b0001, 4'b0001, 4'b0000, 3'd0, 3'd0, 1, -15, 0);
        wait_valid("ch1_min");
        start(4'd9, 4'd9, 4'd15, 4'd9, 4'b0000, 4'b0100, 4'b0100, 3'd3, 3'd3, 1, 0, 0);
        wait_valid("ch3_dac_off");
        // c = 5,-9,1,-15 ; L=(5-9)*3=-12 ; R=(1-15)*6=-84.
        start(4'd10, 4'd3, 4'd8, 4'd0, 4'hF, 4'b0011, 4'b1100, 3'd2, 3'd5, 1, -12, -84);
        wait_valid("mixed");
        start(4'd0, 4'd0, 4'd0, 4'd0, 4'hF, 4'hF, 4'hF, 3'd7, 3'd0, 1, -480, -60);
        wait_valid("all_min");
        chk("no_overrun_on_coincident_stb", int'(overrun), 0);

        // Snapshot: ch2 changes to 0 while CH2 is being summed; the sample still uses 15.
        start(4'd0, 4'd15, 4'd0, 4'd0, 4'b0010, 4'b0010, 4'b0000, 3'd0, 3'd0, 1, 15, 0);
        @(posedge clk); #1; lat++;
        ch2_dac = 4'd0;
        wait_valid("snapshot");

        // Overrun: second strobe 3 clocks after the first is dropped; first sample is 4*1*2 = 8.
        start(4'd8, 4'd8, 4'd8, 4'd8, 4'hF, 4'hF, 4'h0, 3'd1, 3'd0, 1, 8, 0);
        repeat (2) begin @(posedge clk); #1; lat++; end
        ch1_dac = 4'd15; ch2_dac = 4'd15; ch3_dac = 4'd15; ch4_dac = 4'd15;
        rmixer = 4'hF; lvol = 3'd7; rvol = 3'd7;
        sample_stb = 1'b1;
        @(posedge clk); #1; lat++;
        sample_stb = 1'b0;
        wait_valid("overrun_first");
        chk("overrun_set", int'(overrun), 1);
        repeat (10) @(posedge clk);
        #1;
        chk("idle_after_overrun", int'(busy), 0);

        // c = 9 each ; L=18*1 ; R=18*4.
        start(4'd12, 4'd12, 4'd12, 4'd12, 4'hF, 4'b0101, 4'b1010, 3'd0, 3'd3, 1, 18, 72);
        wait_valid("after_overrun");
        chk("overrun_sticky", int'(overrun), 1);

        // Reset while in CH2: sample aborted, everything cleared.
        start(4'd15, 4'd15, 4'd15, 4'd15, 4'hF, 4'hF, 4'hF, 3'd7, 3'd7, 0, 0, 0);
        @(posedge clk); #1;
        chk("busy_in_ch2", int'(busy), 1);
        apu_reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_left", int'(left_out), 0);
        chk("midrst_right", int'(right_out), 0);
        chk("midrst_valid", int'(out_valid), 0);
        chk("midrst_overrun", int'(overrun), 0);
        apu_reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        // c = 15,-15,15,-15 ; L=30*5=150 ; R=-30*2=-60.
        start(4'd15, 4'd0, 4'd15, 4'd0, 4'hF, 4'b0101, 4'b1010, 3'd4, 3'd1, 1, 150, -60);
        wait_valid("after_reset");

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000 time units, expected earlier finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
